// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_param
// Description : Parameterised UART receiver with 3-sample majority voting,
//               optional parity and one or two checked stop bits.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_param #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 RST_clk,
    input  logic                 RST_n,
    input  logic                 uart_rx_data,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int c_baud_div = CLK_FREQ / BAUD;
    localparam int c_mid      = c_baud_div / 2;
    localparam int c_cnt_w    = $clog2(c_baud_div);
    localparam int c_bit_w    = $clog2(DATA_BITS);

    localparam logic [c_cnt_w-1:0] c_smp0     = c_cnt_w'(c_mid - 1);
    localparam logic [c_cnt_w-1:0] c_smp1     = c_cnt_w'(c_mid);
    localparam logic [c_cnt_w-1:0] c_smp2     = c_cnt_w'(c_mid + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_baud_div - 1);
    localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(DATA_BITS - 1);
    localparam logic [c_bit_w-1:0] c_stp_last = c_bit_w'(STOP_BITS - 1);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_start  = 3'd1;
    localparam logic [2:0] c_st_data   = 3'd2;
    localparam logic [2:0] c_st_parity = 3'd3;
    localparam logic [2:0] c_st_stop   = 3'd4;

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_prev;
    logic [2:0]           r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_bit_w-1:0]   r_bitcnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_smp0;
    logic                 r_smp1;
    logic                 r_par_err;
    logic                 r_frm_err;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_parity_err;
    logic                 r_frame_err;

    logic w_fall;
    logic w_maj;
    logic w_decide;
    logic w_bit_end;
    logic w_par_sum;
    logic w_par_bad;

    // Falling edge needs a high-to-low transition, so a held-low (break) line never restarts a frame
    assign w_fall    = r_prev & ~r_sync2;
    assign w_maj     = (r_smp0 & r_smp1) | (r_smp0 & r_sync2) | (r_smp1 & r_sync2);
    assign w_decide  = (r_cnt == c_smp2);
    assign w_bit_end = (r_cnt == c_cnt_last);
    assign w_par_sum = (^r_shift) ^ w_maj;
    assign w_par_bad = (PARITY == 1) ? ~w_par_sum : w_par_sum;

    always_ff @(posedge RST_clk or negedge RST_n) begin
        if (!RST_n) begin
            r_sync1      <= 1'b1;
            r_sync2      <= 1'b1;
            r_prev       <= 1'b1;
            r_state      <= c_st_idle;
            r_cnt        <= '0;
            r_bitcnt     <= '0;
            r_shift      <= '0;
            r_smp0       <= 1'b0;
            r_smp1       <= 1'b0;
            r_par_err    <= 1'b0;
            r_frm_err    <= 1'b0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_sync1    <= uart_rx_data;
            r_sync2    <= r_sync1;
            r_prev     <= r_sync2;
            r_rx_valid <= 1'b0;

            if (r_cnt == c_smp0) r_smp0 <= r_sync2;
            if (r_cnt == c_smp1) r_smp1 <= r_sync2;

            if (r_state == c_st_idle) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= w_bit_end ? '0 : r_cnt + 1'b1;
            end

            case (r_state)
                c_st_idle: begin
                    if (w_fall) begin
                        r_state   <= c_st_start;
                        r_bitcnt  <= '0;
                        r_par_err <= 1'b0;
                        r_frm_err <= 1'b0;
                    end
                end
                c_st_start: begin
                    if (w_decide && w_maj) begin
                        r_state <= c_st_idle;
                    end else if (w_bit_end) begin
                        r_state  <= c_st_data;
                        r_bitcnt <= '0;
                    end
                end
                c_st_data: begin
                    if (w_decide) r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
                    if (w_bit_end) begin
                        if (r_bitcnt == c_bit_last) begin
                            r_bitcnt <= '0;
                            r_state  <= (PARITY != 0) ? c_st_parity : c_st_stop;
                        end else begin
                            r_bitcnt <= r_bitcnt + 1'b1;
                        end
                    end
                end
                c_st_parity: begin
                    if (w_decide) r_par_err <= w_par_bad;
                    if (w_bit_end) begin
                        r_state  <= c_st_stop;
                        r_bitcnt <= '0;
                    end
                end
                c_st_stop: begin
                    // Final stop bit is reported at its decision point, leaving room for a back-to-back start edge
                    if (w_decide) begin
                        if (r_bitcnt == c_stp_last) begin
                            r_rx_data    <= r_shift;
                            r_parity_err <= r_par_err;
                            r_frame_err  <= r_frm_err | ~w_maj;
                            r_rx_valid   <= 1'b1;
                            r_state      <= c_st_idle;
                        end else if (!w_maj) begin
                            r_frm_err <= 1'b1;
                        end
                    end
                    if (w_bit_end) r_bitcnt <= r_bitcnt + 1'b1;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign busy       = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_param
// Description : Self-checking bench for uart_rx_param (8N1, 8E1, 8N2, 9O1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_param;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 100_000;
    localparam int BIT_CLKS = CLK_FREQ / BAUD;

    typedef struct packed {
        logic [8:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       clk = 1'b0;
    logic       RST_n;
    logic [3:0] line;

    logic [7:0] d0, d1, d2;
    logic [8:0] d3;
    logic       v0, v1, v2, v3;
    logic       pe0, pe1, pe2, pe3;
    logic       fe0, fe1, fe2, fe3;
    logic       b0, b1, b2, b3;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t q3[$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_n1 (
        .RST_clk(clk), .RST_n(RST_n), .uart_rx_data(line[0]),
        .rx_data(d0), .rx_valid(v0), .parity_err(pe0), .frame_err(fe0), .busy(b0));
    uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_e1 (
        .RST_clk(clk), .RST_n(RST_n), .uart_rx_data(line[1]),
        .rx_data(d1), .rx_valid(v1), .parity_err(pe1), .frame_err(fe1), .busy(b1));
    uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_n2 (
        .RST_clk(clk), .RST_n(RST_n), .uart_rx_data(line[2]),
        .rx_data(d2), .rx_valid(v2), .parity_err(pe2), .frame_err(fe2), .busy(b2));
    uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(9), .PARITY(1), .STOP_BITS(1)) u_o9 (
        .RST_clk(clk), .RST_n(RST_n), .uart_rx_data(line[3]),
        .rx_data(d3), .rx_valid(v3), .parity_err(pe3), .frame_err(fe3), .busy(b3));

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int cfg_bits(input int idx);
        return (idx == 3) ? 9 : 8;
    endfunction

    function automatic int cfg_par(input int idx);
        return (idx == 1) ? 2 : ((idx == 3) ? 1 : 0);
    endfunction

    function automatic int cfg_stop(input int idx);
        return (idx == 2) ? 2 : 1;
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input int idx, input exp_t e);
        case (idx)
            0: q0.push_back(e);
            1: q1.push_back(e);
            2: q2.push_back(e);
            default: q3.push_back(e);
        endcase
    endtask

    // Model: frame built from the line format rules; expectations follow from what was sent
    task automatic send_frame(input int idx, input logic [8:0] data, input logic bad_par, input logic [1:0] stops);
        int         n;
        int         nb;
        int         ones;
        logic [15:0] bits;
        logic [8:0] masked;
        logic       pbit;
        exp_t       e;
        n      = cfg_bits(idx);
        masked = data & 9'((1 << n) - 1);
        bits   = '0;
        nb     = 1;
        for (int i = 0; i < n; i++) begin
            bits[nb] = masked[i];
            nb++;
        end
        e.d  = masked;
        e.pe = 1'b0;
        if (cfg_par(idx) != 0) begin
            ones = $countones(masked);
            pbit = (cfg_par(idx) == 2) ? ones[0] : ~ones[0];
            bits[nb] = pbit ^ bad_par;
            nb++;
            e.pe = bad_par;
        end
        e.fe = 1'b0;
        for (int s = 0; s < cfg_stop(idx); s++) begin
            bits[nb] = stops[s];
            if (!stops[s]) e.fe = 1'b1;
            nb++;
        end
        push_exp(idx, e);
        for (int i = 0; i < nb; i++) begin
            line[idx] = bits[i];
            wait_clks(BIT_CLKS);
        end
    endtask

    task automatic mon(input int idx, input logic [8:0] d, input logic pe, input logic fe, input logic bz);
        exp_t e;
        int   sz;
        case (idx)
            0: sz = q0.size();
            1: sz = q1.size();
            2: sz = q2.size();
            default: sz = q3.size();
        endcase
        check_eq($sformatf("valid_expected_dut%0d", idx), 32'(sz > 0), 32'd1);
        if (sz > 0) begin
            case (idx)
                0: e = q0.pop_front();
                1: e = q1.pop_front();
                2: e = q2.pop_front();
                default: e = q3.pop_front();
            endcase
            check_eq($sformatf("rx_data_dut%0d", idx), 32'(d), 32'(e.d));
            check_eq($sformatf("parity_err_dut%0d", idx), 32'(pe), 32'(e.pe));
            check_eq($sformatf("frame_err_dut%0d", idx), 32'(fe), 32'(e.fe));
            check_eq($sformatf("busy_at_valid_dut%0d", idx), 32'(bz), 32'd0);
        end
    endtask

    always @(negedge clk) begin
        if (v0) mon(0, {1'b0, d0}, pe0, fe0, b0);
        if (v1) mon(1, {1'b0, d1}, pe1, fe1, b1);
        if (v2) mon(2, {1'b0, d2}, pe2, fe2, b2);
        if (v3) mon(3, d3, pe3, fe3, b3);
    end

    task automatic rand_run(input int idx, input int nframes);
        logic [8:0] data;
        logic       bad;
        logic [1:0] stops;
        int         gap;
        for (int k = 0; k < nframes; k++) begin
            data  = 9'($urandom);
            bad   = (cfg_par(idx) != 0) && ($urandom_range(3) == 0);
            stops = 2'b11;
            if ($urandom_range(4) == 0) stops[0] = 1'b0;
            if (cfg_stop(idx) == 2 && $urandom_range(4) == 0) stops[1] = 1'b0;
            send_frame(idx, data, bad, stops);
            gap = $urandom_range(24);
            // A low final stop needs the line to return high before the next start edge
            if (!stops[cfg_stop(idx) - 1]) gap += BIT_CLKS;
            line[idx] = 1'b1;
            if (gap > 0) wait_clks(gap);
        end
    endtask

    initial begin
        RST_n = 1'b0;
        line  = 4'hF;
        wait_clks(3);
        check_eq("reset_rx_data", 32'(d0), 32'd0);
        check_eq("reset_rx_valid", 32'(v0), 32'd0);
        check_eq("reset_parity_err", 32'(pe1), 32'd0);
        check_eq("reset_frame_err", 32'(fe2), 32'd0);
        check_eq("reset_busy", 32'(b3), 32'd0);
        RST_n = 1'b1;
        wait_clks(20);

        // 8N1 basic frame
        send_frame(0, 9'h0A5, 1'b0, 2'b11);
        line[0] = 1'b1;
        wait_clks(32);

        // 8E1 wrong then correct parity; errors hold between strobes
        send_frame(1, 9'h037, 1'b1, 2'b11);
        line[1] = 1'b1;
        wait_clks(32);
        check_eq("hold_parity_err", 32'(pe1), 32'd1);
        check_eq("hold_rx_data", 32'(d1), 32'h37);
        send_frame(1, 9'h037, 1'b0, 2'b11);
        line[1] = 1'b1;
        wait_clks(32);

        // 8N2 second stop low, then break for 5 bit times
        send_frame(2, 9'h03C, 1'b0, 2'b01);
        wait_clks(5 * BIT_CLKS);
        check_eq("break_busy", 32'(b2), 32'd0);
        check_eq("break_frame_err_held", 32'(fe2), 32'd1);
        line[2] = 1'b1;
        wait_clks(32);

        // 4-clock glitch rejected
        line[0] = 1'b0;
        wait_clks(4);
        check_eq("glitch_busy_seen", 32'(b0), 32'd1);
        line[0] = 1'b1;
        wait_clks(BIT_CLKS);
        check_eq("glitch_busy_cleared", 32'(b0), 32'd0);
        wait_clks(32);

        // Back-to-back frames, no idle gap
        send_frame(0, 9'h000, 1'b0, 2'b11);
        send_frame(0, 9'h0FF, 1'b0, 2'b11);
        send_frame(0, 9'h055, 1'b0, 2'b11);
        line[0] = 1'b1;
        wait_clks(32);

        // 9-bit odd parity: good then bad
        send_frame(3, 9'h1A5, 1'b0, 2'b11);
        send_frame(3, 9'h0F0, 1'b1, 2'b11);
        line[3] = 1'b1;
        wait_clks(32);

        // Reset during data bit 3 of 0x81
        line[0] = 1'b0;
        wait_clks(BIT_CLKS);
        line[0] = 1'b1;
        wait_clks(BIT_CLKS);
        line[0] = 1'b0;
        wait_clks(2 * BIT_CLKS + BIT_CLKS / 2);
        check_eq("pre_reset_busy", 32'(b0), 32'd1);
        RST_n = 1'b0;
        #1;
        check_eq("midreset_rx_data", 32'(d0), 32'd0);
        check_eq("midreset_rx_valid", 32'(v0), 32'd0);
        check_eq("midreset_busy", 32'(b0), 32'd0);
        check_eq("midreset_frame_err", 32'(fe0), 32'd0);
        line[0] = 1'b1;
        wait_clks(2);
        RST_n = 1'b1;
        wait_clks(32);
        check_eq("postreset_busy", 32'(b0), 32'd0);
        send_frame(0, 9'h081, 1'b0, 2'b11);
        line[0] = 1'b1;
        wait_clks(32);

        // Randomised traffic on all four configurations at once
        fork
            rand_run(0, 20);
            rand_run(1, 20);
            rand_run(2, 20);
            rand_run(3, 20);
        join
        line = 4'hF;
        wait_clks(64);

        check_eq("drained_dut0", 32'(q0.size()), 32'd0);
        check_eq("drained_dut1", 32'(q1.size()), 32'd0);
        check_eq("drained_dut2", 32'(q2.size()), 32'd0);
        check_eq("drained_dut3", 32'(q3.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
